// File: rtl/t04_lcd_pkg.sv
// Shared command codes and receiver state for the 8080-style LCD bus receiver.
// Imported by the synchronizer front end and the decoder top.
package t04_lcd_pkg;

    localparam logic [7:0] CMD_SWRST   = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;

    localparam logic [7:0] COLMOD_RST  = 8'h66;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_COLMOD,
        ST_MADCTL,
        ST_RAMWR
    } rx_state_t;

    // State a command byte leads into; anything without parameters idles.
    function automatic rx_state_t cmd_target(input logic [7:0] c);
        rx_state_t s;
        s = ST_IDLE;
        case (c)
            CMD_CASET:  s = ST_CASET;
            CMD_PASET:  s = ST_PASET;
            CMD_COLMOD: s = ST_COLMOD;
            CMD_MADCTL: s = ST_MADCTL;
            CMD_RAMWR:  s = ST_RAMWR;
            default:    s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/t04_lcd_bus_sync.sv
// Synchronizes the asynchronous write bus and turns wrx rising edges
// (while selected) into single-cycle byte strobes.
module t04_lcd_bus_sync
    import t04_lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       csx,
    input  logic       dcx,
    input  logic       wrx,
    input  logic [7:0] data,
    output logic       byte_strb,
    output logic       byte_dcx,
    output logic [7:0] byte_data,
    output logic       csx_rise
);

    logic [SYNC_STAGES-1:0]      csx_q;
    logic [SYNC_STAGES-1:0]      dcx_q;
    logic [SYNC_STAGES-1:0]      wrx_q;
    logic [SYNC_STAGES-1:0][7:0] data_q;
    logic                        wrx_d;
    logic                        csx_d;
    logic                        csx_s;
    logic                        wrx_s;

    // Idle-high strobes reset high so a held-high bus gives no false edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            csx_q  <= '1;
            dcx_q  <= '0;
            wrx_q  <= '1;
            data_q <= '0;
            wrx_d  <= 1'b1;
            csx_d  <= 1'b1;
        end else begin
            csx_q  <= {csx_q[SYNC_STAGES-2:0], csx};
            dcx_q  <= {dcx_q[SYNC_STAGES-2:0], dcx};
            wrx_q  <= {wrx_q[SYNC_STAGES-2:0], wrx};
            data_q <= {data_q[SYNC_STAGES-2:0], data};
            wrx_d  <= wrx_s;
            csx_d  <= csx_s;
        end
    end

    assign csx_s     = csx_q[SYNC_STAGES-1];
    assign wrx_s     = wrx_q[SYNC_STAGES-1];
    assign byte_dcx  = dcx_q[SYNC_STAGES-1];
    assign byte_data = data_q[SYNC_STAGES-1];
    assign byte_strb = wrx_s & ~wrx_d & ~csx_s;
    assign csx_rise  = csx_s & ~csx_d;

endmodule

// File: rtl/t04_lcd_bus_receiver.sv
// Panel-side decoder for the 8080 write bus: command/parameter parsing,
// panel state registers and RGB565 pixel strobes with coordinates.
module t04_lcd_bus_receiver
    import t04_lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int X_MAX       = 239,
    parameter int Y_MAX       = 319
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        csx,
    input  logic        dcx,
    input  logic        wrx,
    input  logic [7:0]  data,
    output logic        cmd_valid,
    output logic [7:0]  cmd,
    output logic [15:0] x_start,
    output logic [15:0] x_end,
    output logic [15:0] y_start,
    output logic [15:0] y_end,
    output logic [7:0]  colmod,
    output logic [7:0]  madctl,
    output logic        sleep,
    output logic        disp_on,
    output logic        pix_valid,
    output logic [15:0] pix,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y
);

    localparam logic [15:0] XM = 16'(X_MAX);
    localparam logic [15:0] YM = 16'(Y_MAX);

    logic        byte_strb;
    logic        byte_dcx;
    logic [7:0]  byte_data;
    logic        csx_rise;
    logic        cmdb;
    logic        par;

    rx_state_t   state_q;
    rx_state_t   state_d;
    logic [1:0]  cnt_q;
    logic        phase_q;
    logic [7:0]  b0_q;
    logic [15:0] sh_s_q;
    logic [7:0]  sh_e_q;
    logic [15:0] cur_x;
    logic [15:0] cur_y;

    t04_lcd_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .nrst     (nrst),
        .csx      (csx),
        .dcx      (dcx),
        .wrx      (wrx),
        .data     (data),
        .byte_strb(byte_strb),
        .byte_dcx (byte_dcx),
        .byte_data(byte_data),
        .csx_rise (csx_rise)
    );

    assign cmdb = byte_strb & ~byte_dcx;
    assign par  = byte_strb & byte_dcx;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (csx_rise) begin
            state_d = ST_IDLE;
        end else if (cmdb) begin
            state_d = cmd_target(byte_data);
        end else if (par) begin
            unique case (state_q)
                ST_CASET,
                ST_PASET: if (cnt_q == 2'd3) state_d = ST_IDLE;
                ST_COLMOD,
                ST_MADCTL: state_d = ST_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cmd_valid <= 1'b0;
            cmd       <= '0;
            x_start   <= '0;
            x_end     <= XM;
            y_start   <= '0;
            y_end     <= YM;
            colmod    <= COLMOD_RST;
            madctl    <= '0;
            sleep     <= 1'b1;
            disp_on   <= 1'b0;
            pix_valid <= 1'b0;
            pix       <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            b0_q      <= '0;
            sh_s_q    <= '0;
            sh_e_q    <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
        end else begin
            cmd_valid <= cmdb;
            pix_valid <= 1'b0;
            if (csx_rise) begin
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else if (cmdb) begin
                cmd     <= byte_data;
                cnt_q   <= '0;
                phase_q <= 1'b0;
                case (byte_data)
                    CMD_SWRST: begin
                        x_start <= '0;
                        x_end   <= XM;
                        y_start <= '0;
                        y_end   <= YM;
                        colmod  <= COLMOD_RST;
                        madctl  <= '0;
                        sleep   <= 1'b1;
                        disp_on <= 1'b0;
                        pix     <= '0;
                        pix_x   <= '0;
                        pix_y   <= '0;
                        cur_x   <= '0;
                        cur_y   <= '0;
                    end
                    CMD_SLPIN:   sleep   <= 1'b1;
                    CMD_SLPOUT:  sleep   <= 1'b0;
                    CMD_DISPOFF: disp_on <= 1'b0;
                    CMD_DISPON:  disp_on <= 1'b1;
                    CMD_RAMWR: begin
                        cur_x <= x_start;
                        cur_y <= y_start;
                        pix_x <= x_start;
                        pix_y <= y_start;
                    end
                    default: ;
                endcase
            end else if (par) begin
                unique case (state_q)
                    ST_CASET, ST_PASET: begin
                        cnt_q <= cnt_q + 2'd1;
                        // Window only moves once all four bytes have arrived.
                        unique case (cnt_q)
                            2'd0: sh_s_q[15:8] <= byte_data;
                            2'd1: sh_s_q[7:0]  <= byte_data;
                            2'd2: sh_e_q       <= byte_data;
                            default: begin
                                if (state_q == ST_CASET) begin
                                    x_start <= sh_s_q;
                                    x_end   <= {sh_e_q, byte_data};
                                end else begin
                                    y_start <= sh_s_q;
                                    y_end   <= {sh_e_q, byte_data};
                                end
                            end
                        endcase
                    end
                    ST_COLMOD: colmod <= byte_data;
                    ST_MADCTL: madctl <= byte_data;
                    ST_RAMWR: begin
                        if (!phase_q) begin
                            b0_q    <= byte_data;
                            phase_q <= 1'b1;
                        end else begin
                            phase_q   <= 1'b0;
                            pix       <= {b0_q, byte_data};
                            pix_valid <= 1'b1;
                            pix_x     <= cur_x;
                            pix_y     <= cur_y;
                            if (cur_x == x_end) begin
                                cur_x <= x_start;
                                cur_y <= (cur_y == y_end) ?
                                         y_start : cur_y + 16'd1;
                            end else begin
                                cur_x <= cur_x + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
